// File: rtl/nbit_deshifter_if.sv
// Parallel-side bundle of the serial receiver: serial input, clear, and the held
// output word with its valid/ready handshake, overrun, bit count and parity status.
interface nbit_deshifter_if #(
   parameter int n = 16
);
   localparam int CW = $clog2(n + 1);

   logic          shift_ena;
   logic          sin;
   logic          clear;
   logic          ready;
   logic [n-1:0]  outp;
   logic          valid;
   logic          overrun;
   logic [CW-1:0] bit_cnt;
   logic          perr;

   modport master (
      output shift_ena, sin, clear, ready,
      input  outp, valid, overrun, bit_cnt, perr
   );

   modport slave (
      input  shift_ena, sin, clear, ready,
      output outp, valid, overrun, bit_cnt, perr
   );
endinterface

// File: rtl/nbit_deshifter.sv
// Serial-in/parallel-out receiver, MSB first, with held output, valid/ready and sticky overrun.
// Define PARITY_CHECK_EN to expect an even-parity bit after each word (adds the PARITY state).
module nbit_deshifter #(
   parameter int n = 16
) (
   input logic            clock,
   input logic            reset,
   nbit_deshifter_if.slave bus
);
   localparam int            CW   = $clog2(n + 1);
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   logic [n-1:0]  outp_q, outp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;
   logic          deliver;
   logic [n-1:0]  del_data;

`ifdef PARITY_CHECK_EN
   typedef enum logic {RECV, PARITY} state_e;
   state_e       state_q, state_d;
   logic [n-1:0] shreg_q, shreg_d;
   logic         perr_q, perr_d;

   always_ff @(posedge clock) begin
      if (!reset) state_q <= RECV;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.clear)
         state_d = RECV;
      else if (bus.shift_ena) begin
         if (state_q == PARITY)  state_d = RECV;
         else if (cnt_q == LAST) state_d = PARITY;
      end
   end

   // In PARITY the complete word waits in shreg for its parity bit.
   always_comb begin
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      perr_d   = perr_q;
      deliver  = 1'b0;
      del_data = shreg_q;
      if (bus.clear) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (bus.shift_ena) begin
         if (state_q == PARITY) begin
            deliver = 1'b1;
            perr_d  = (^shreg_q) ^ bus.sin;
            shreg_d = '0;
         end else begin
            shreg_d = {shreg_q[n-2:0], bus.sin};
            cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         shreg_q <= '0;
         perr_q  <= 1'b0;
      end else begin
         shreg_q <= shreg_d;
         perr_q  <= perr_d;
      end
   end

   assign bus.perr = perr_q;
`else
   // Only n-1 bits need storing; the last bit goes straight from sin to outp.
   logic [n-2:0] shreg_q, shreg_d;

   always_comb begin
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      deliver  = 1'b0;
      del_data = {shreg_q, bus.sin};
      if (bus.clear) begin
         shreg_d = '0;
         cnt_d   = '0;
      end else if (bus.shift_ena) begin
         if (cnt_q == LAST) begin
            deliver = 1'b1;
            shreg_d = '0;
            cnt_d   = '0;
         end else begin
            shreg_d = del_data[n-2:0];
            cnt_d   = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) shreg_q <= '0;
      else        shreg_q <= shreg_d;
   end

   assign bus.perr = 1'b0;
`endif

   // A completing word wins over a consume on the same edge and keeps valid high.
   always_comb begin
      outp_d  = outp_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (bus.clear)
         ovr_d = 1'b0;
      else if (deliver) begin
         outp_d  = del_data;
         valid_d = 1'b1;
         if (valid_q && !bus.ready) ovr_d = 1'b1;
      end else if (valid_q && bus.ready)
         valid_d = 1'b0;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         outp_q  <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         outp_q  <= outp_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.outp    = outp_q;
   assign bus.valid   = valid_q;
   assign bus.overrun = ovr_q;
   assign bus.bit_cnt = cnt_q;
endmodule

// File: tb/tb_nbit_deshifter.sv
// Bench for nbit_deshifter: queue-based receiver model checked every cycle, plus
// directed literal expectations for the reset, handshake, overrun, clear and parity cases.
module tb_nbit_deshifter;
   localparam int N  = 16;
   localparam int CW = $clog2(N + 1);

   logic clock;
   logic reset;

   nbit_deshifter_if #(.n(N)) bus ();

   nbit_deshifter #(.n(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: bits of the word in progress are kept in a queue; a word is the
   // queue read MSB first once it holds N bits.
   bit          mq[$];
   logic [N-1:0] m_outp, m_data;
   logic        m_valid, m_ovr, m_perr, m_pend;
   bit          started = 0;

   function automatic logic [N-1:0] q_to_word();
      logic [N-1:0] w;
      w = '0;
      for (int i = 0; i < N; i++) w = N'(w * 2 + N'(mq[i]));
      return w;
   endfunction

   always @(posedge clock) begin : model
      logic         dlv;
      logic [N-1:0] dd;
      dlv = 1'b0;
      dd  = '0;
      if (!reset) begin
         mq.delete();
         m_outp = '0; m_valid = 0; m_ovr = 0; m_perr = 0; m_pend = 0;
      end else if (bus.clear) begin
         mq.delete();
         m_ovr = 0; m_pend = 0;
      end else begin
         if (bus.shift_ena) begin
            if (m_pend) begin
               dlv    = 1'b1;
               dd     = m_data;
               m_perr = 1'(($countones(m_data) + int'(bus.sin)) % 2);
               m_pend = 0;
            end else begin
               mq.push_back(bus.sin);
               if (mq.size() == N) begin
                  dd = q_to_word();
                  mq.delete();
`ifdef PARITY_CHECK_EN
                  m_pend = 1;
                  m_data = dd;
`else
                  dlv = 1'b1;
`endif
               end
            end
         end
         if (dlv) begin
            if (m_valid && !bus.ready) m_ovr = 1;
            m_outp  = dd;
            m_valid = 1;
         end else if (m_valid && bus.ready) begin
            m_valid = 0;
         end
      end
      started = 1;
   end

   always @(negedge clock) begin
      if (started) begin
         check("cyc_outp",    32'(bus.outp),    32'(m_outp));
         check("cyc_valid",   32'(bus.valid),   32'(m_valid));
         check("cyc_overrun", 32'(bus.overrun), 32'(m_ovr));
         check("cyc_bit_cnt", 32'(bus.bit_cnt), 32'(mq.size()));
         check("cyc_perr",    32'(bus.perr),    32'(m_perr));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send_range(input logic [N-1:0] w, input int hi, input int lo, input bit gaps);
      for (int i = hi; i >= lo; i--) begin
         if (gaps) begin
            bus.shift_ena = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         bus.shift_ena = 1'b1;
         bus.sin       = w[i];
         tick();
      end
      bus.shift_ena = 1'b0;
   endtask

   task automatic send_word(input logic [N-1:0] w, input bit gaps);
      send_range(w, N - 1, 0, gaps);
`ifdef PARITY_CHECK_EN
      bus.shift_ena = 1'b1;
      bus.sin       = ^w;
      tick();
      bus.shift_ena = 1'b0;
`endif
   endtask

   task automatic pulse_ready();
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
   endtask

   initial begin
      reset         = 1'b0;
      bus.clear     = 1'b0;
      bus.ready     = 1'b0;
      bus.shift_ena = 1'b0;
      bus.sin       = 1'b0;

      // Reset held with random serial activity
      for (int k = 0; k < 2; k++) begin
         bus.shift_ena = 1'($urandom_range(0, 1));
         bus.sin       = 1'($urandom_range(0, 1));
         tick();
      end
      check("rst_outp",    32'(bus.outp),    32'h0);
      check("rst_valid",   32'(bus.valid),   32'h0);
      check("rst_overrun", 32'(bus.overrun), 32'h0);
      check("rst_bit_cnt", 32'(bus.bit_cnt), 32'h0);
      check("rst_perr",    32'(bus.perr),    32'h0);

      // First word 5555, bit count walks 1..15 then 0
      reset = 1'b1;
      begin
         logic [N-1:0] w;
         w = 16'h5555;
         for (int k = 0; k < N; k++) begin
            bus.shift_ena = 1'b1;
            bus.sin       = w[N-1-k];
            tick();
            check("w1_bit_cnt", 32'(bus.bit_cnt), 32'((k + 1) % N));
         end
         bus.shift_ena = 1'b0;
`ifdef PARITY_CHECK_EN
         check("w1_valid_wait", 32'(bus.valid), 32'h0);
         bus.shift_ena = 1'b1;
         bus.sin       = 1'b0;
         tick();
         bus.shift_ena = 1'b0;
`endif
      end
      check("w1_outp",  32'(bus.outp),  32'h5555);
      check("w1_valid", 32'(bus.valid), 32'h1);

      // Consume, then back-to-back 5555 / A5A5 with ready pulsed during the second
      pulse_ready();
      check("hs_valid_drop", 32'(bus.valid), 32'h0);
      send_word(16'h5555, 0);
      check("b2b_first", 32'(bus.outp), 32'h5555);
      bus.ready     = 1'b1;
      bus.shift_ena = 1'b1;
      bus.sin       = 1'b1;
      tick();
      bus.ready = 1'b0;
      check("b2b_consumed", 32'(bus.valid), 32'h0);
      send_range(16'hA5A5, N - 2, 0, 0);
`ifdef PARITY_CHECK_EN
      bus.shift_ena = 1'b1;
      bus.sin       = ^16'hA5A5;
      tick();
      bus.shift_ena = 1'b0;
`endif
      check("b2b_outp",    32'(bus.outp),    32'hA5A5);
      check("b2b_valid",   32'(bus.valid),   32'h1);
      check("b2b_overrun", 32'(bus.overrun), 32'h0);

      // Overrun and its clear
      pulse_ready();
      send_word(16'h1234, 0);
      send_word(16'hBEEF, 0);
      check("ovr_flag",  32'(bus.overrun), 32'h1);
      check("ovr_outp",  32'(bus.outp),    32'hBEEF);
      check("ovr_valid", 32'(bus.valid),   32'h1);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("clr_overrun", 32'(bus.overrun), 32'h0);
      check("clr_outp",    32'(bus.outp),    32'hBEEF);
      check("clr_valid",   32'(bus.valid),   32'h1);

      // Partial word aborted by clear, then a gapped word
      pulse_ready();
      send_range(16'hFE00, N - 1, N - 7, 0);
      check("part_cnt", 32'(bus.bit_cnt), 32'd7);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("abort_cnt", 32'(bus.bit_cnt), 32'h0);
      send_word(16'h00FF, 1);
      check("gap_outp",  32'(bus.outp),  32'h00FF);
      check("gap_valid", 32'(bus.valid), 32'h1);

      // Reset mid-word, then a clean word
      pulse_ready();
      send_range(16'hFFFF, N - 1, N - 5, 0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mrst_outp",    32'(bus.outp),    32'h0);
      check("mrst_valid",   32'(bus.valid),   32'h0);
      check("mrst_bit_cnt", 32'(bus.bit_cnt), 32'h0);
      send_word(16'hF00F, 0);
      check("post_rst_outp",  32'(bus.outp),  32'hF00F);
      check("post_rst_valid", 32'(bus.valid), 32'h1);
      check("base_perr",      32'(bus.perr),  32'h0);

`ifdef PARITY_CHECK_EN
      // Parity: good bit, then bad bit
      pulse_ready();
      send_range(16'h0001, N - 1, 0, 0);
      check("par_wait", 32'(bus.valid), 32'h0);
      bus.shift_ena = 1'b1;
      bus.sin       = 1'b1;
      tick();
      bus.shift_ena = 1'b0;
      check("par_good_valid", 32'(bus.valid), 32'h1);
      check("par_good_perr",  32'(bus.perr),  32'h0);
      pulse_ready();
      send_range(16'h0001, N - 1, 0, 0);
      bus.shift_ena = 1'b1;
      bus.sin       = 1'b0;
      tick();
      bus.shift_ena = 1'b0;
      check("par_bad_perr", 32'(bus.perr), 32'h1);
      check("par_bad_outp", 32'(bus.outp), 32'h0001);
`endif

      tick();
      @(negedge clock);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
